cpu_control_unit: RTL and testbench
===================================

# cpu_control_unit

Multi-cycle control unit that sequences the 16-bit RISC memory and datapath: fetches instructions from the 256-word memory, decodes them, and drives every memory-bank and datapath control strobe. Sits beside the memory/datapath top level and owns all of its control inputs. Software starts and stops it with a start/halted handshake.

## Interface
- No parameters; address width 8, instruction width 16, register index 4 are fixed.
- `CLK100MHZ` in 1: sole clock, rising edge.
- `RESET` in 1: synchronous, active-high reset.
- `start` in 1: pulse; leaves IDLE and begins fetching at current PC.
- `mb_data_out` in 16: memory read data (instruction or load data).
- `dp_zf_flag` in 1: datapath ALU zero flag.
- `mb_sel` out 1: memory address mux; 0 = PC, 1 = CU address.
- `mb_pc_addr`, `mb_cu_addr` out 8: fetch and data addresses.
- `mb_mem_read`, `mb_mem_write` out 1: memory strobes.
- `dp_imm` out 8; `dp_sel` out 2: write-back source; 00 ALU, 01 memory, 10 immediate.
- `dp_write_addr`, `dp_a_addr`, `dp_b_addr` out 4; `dp_write`, `dp_a_read`, `dp_b_read` out 1.
- `dp_alu_sel` out 4; `halted` out 1; `illegal` out 1; `pc` out 8 (debug).

## Operation
- Format: op[15:12], rd[11:8], ra[7:4], rb[3:0]; imm8 = [7:0].
- Opcodes: 0 NOP, 1 LD rd←M[imm8], 2 ST M[imm8]←rd, 3 LDI rd←imm8, 4 JMP imm8, 5 JZ imm8 (if Z), 6 HALT, 7 reserved, 8–F ALU rd←ra op rb with `dp_alu_sel` = {0, op[14:12]}.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB.
- IDLE: all strobes low; `start`=1 → FETCH. `start` ignored outside IDLE.
- FETCH: `mb_sel`=0, `mb_pc_addr`=PC, `mb_mem_read`=1 → DECODE.
- DECODE: IR←`mb_data_out`, PC←PC+1 (8-bit wrap, FF→00) → EXEC.
- EXEC: ALU: a/b reads asserted with ra/rb → WB. LD: `mb_sel`=1, `mb_cu_addr`=imm8, read → WB. ST: `dp_a_read`=1, `dp_a_addr`=rd → MEM. LDI → WB. JMP: PC←imm8 → FETCH. JZ: PC←imm8 if Z else unchanged → FETCH. NOP → FETCH. HALT → IDLE, `halted`←1.
- MEM (ST): `mb_sel`=1, `mb_cu_addr`=imm8, `mb_mem_write`=1, a-read held → FETCH.
- WB: `dp_write`=1, `dp_write_addr`=rd, `dp_sel` per op, `dp_imm`=imm8 for LDI; ALU keeps reads/alu_sel stable; Z←`dp_zf_flag` on ALU ops only → FETCH.
- `halted` clears when `start` accepted.
- `mb_mem_read` and `mb_mem_write` never high in the same cycle; `dp_write` only in WB.

## Timing
- Memory read data valid the cycle after `mb_mem_read`.
- Cycles per instruction: ALU/LD/ST/LDI 4; JMP/JZ/NOP/HALT 3.
- Outputs registered from state; strobes are single-cycle except held reads.
- Reset (any state, mid-instruction included): state IDLE, PC=00, IR=0000, Z=0, `halted`=0, `illegal`=0, all outputs 0 on the same edge; no partial write completes.

## Configuration
- `CU_ILLEGAL_TRAP_EN` defined: opcode 7 → IDLE with `halted`=1 and `illegal`=1 (sticky until reset or start).
- Undefined: opcode 7 executes as NOP; `illegal` tied 0.

## Structure
- Package `cu_pkg`: opcode constants, state enum, `dp_sel` encodings, field-slice widths.
- Sub-module `cu_decoder`: combinational IR → op class, register indices, imm8, alu_sel.

## Test plan
- Reset, `start`; M[00]=3105 (LDI R1,05) → `dp_write`=1, `dp_write_addr`=1, `dp_sel`=10, `dp_imm`=05 in cycle 4; PC=01.
- M[00]=1240 (LD R2,[40]) → EXEC `mb_sel`=1, `mb_cu_addr`=40; WB `dp_sel`=01, write R2.
- ALU 8312 (R3←R1 op R2, zero result) then JZ 5020 → PC=20 after 7 cycles; nonzero result → PC falls through.
- ST 2180 → MEM cycle `mb_mem_write`=1, `mb_cu_addr`=80, `dp_a_addr`=1; no `dp_write` asserted.
- PC=FF fetching NOP → PC=00; HALT 6000 → `halted`=1, IDLE, `start` resumes at next PC.
- RESET asserted during WB → `dp_write`=0 that edge, PC=00; opcode 7 → `illegal`=1 only with `CU_ILLEGAL_TRAP_EN`.

Source files
------------

// File: rtl/cu_pkg.sv
// Shared types and constants for the multi-cycle control unit: opcodes,
// FSM states, write-back source encodings and the registered control bundle.
package cu_pkg;

   localparam int ADDR_W  = 8;
   localparam int INSTR_W = 16;
   localparam int REG_W   = 4;
   localparam int ALU_W   = 4;

   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_LD   = 4'h1;
   localparam logic [3:0] OP_ST   = 4'h2;
   localparam logic [3:0] OP_LDI  = 4'h3;
   localparam logic [3:0] OP_JMP  = 4'h4;
   localparam logic [3:0] OP_JZ   = 4'h5;
   localparam logic [3:0] OP_HALT = 4'h6;
   localparam logic [3:0] OP_RSVD = 4'h7;

   localparam logic [1:0] DP_SEL_ALU = 2'b00;
   localparam logic [1:0] DP_SEL_MEM = 2'b01;
   localparam logic [1:0] DP_SEL_IMM = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE, ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB
   } state_t;

   typedef enum logic [3:0] {
      CLS_NOP, CLS_LD, CLS_ST, CLS_LDI, CLS_JMP, CLS_JZ, CLS_HALT, CLS_RSVD, CLS_ALU
   } op_class_t;

   typedef struct packed {
      logic              mb_sel;
      logic [ADDR_W-1:0] mb_pc_addr;
      logic [ADDR_W-1:0] mb_cu_addr;
      logic              mb_mem_read;
      logic              mb_mem_write;
      logic [ADDR_W-1:0] dp_imm;
      logic [1:0]        dp_sel;
      logic [REG_W-1:0]  dp_write_addr;
      logic [REG_W-1:0]  dp_a_addr;
      logic [REG_W-1:0]  dp_b_addr;
      logic              dp_write;
      logic              dp_a_read;
      logic              dp_b_read;
      logic [ALU_W-1:0]  dp_alu_sel;
   } ctrl_t;

endpackage

// File: rtl/cu_decoder.sv
// Combinational instruction decoder: splits an instruction word into its
// operation class, register indices, 8-bit immediate and ALU function.
module cu_decoder
   import cu_pkg::*;
(
   input  logic [INSTR_W-1:0] ir,
   output op_class_t          op_class,
   output logic [REG_W-1:0]   rd,
   output logic [REG_W-1:0]   ra,
   output logic [REG_W-1:0]   rb,
   output logic [ADDR_W-1:0]  imm8,
   output logic [ALU_W-1:0]   alu_sel
);

   always_comb begin
      op_class = CLS_ALU;
      case (ir[15:12])
         OP_NOP:  op_class = CLS_NOP;
         OP_LD:   op_class = CLS_LD;
         OP_ST:   op_class = CLS_ST;
         OP_LDI:  op_class = CLS_LDI;
         OP_JMP:  op_class = CLS_JMP;
         OP_JZ:   op_class = CLS_JZ;
         OP_HALT: op_class = CLS_HALT;
         OP_RSVD: op_class = CLS_RSVD;
         default: op_class = CLS_ALU;
      endcase
   end

   assign rd      = ir[11:8];
   assign ra      = ir[7:4];
   assign rb      = ir[3:0];
   assign imm8    = ir[7:0];
   assign alu_sel = {1'b0, ir[14:12]};

endmodule

// File: rtl/cpu_control_unit.sv
// Multi-cycle FSM sequencing fetch/decode/execute for the 16-bit RISC core.
// Define CU_ILLEGAL_TRAP_EN to trap opcode 7 (halt + illegal) instead of NOP.
module cpu_control_unit
   import cu_pkg::*;
(
   input  logic               CLK100MHZ,
   input  logic               RESET,
   input  logic               start,
   input  logic [INSTR_W-1:0] mb_data_out,
   input  logic               dp_zf_flag,
   output logic               mb_sel,
   output logic [ADDR_W-1:0]  mb_pc_addr,
   output logic [ADDR_W-1:0]  mb_cu_addr,
   output logic               mb_mem_read,
   output logic               mb_mem_write,
   output logic [ADDR_W-1:0]  dp_imm,
   output logic [1:0]         dp_sel,
   output logic [REG_W-1:0]   dp_write_addr,
   output logic [REG_W-1:0]   dp_a_addr,
   output logic [REG_W-1:0]   dp_b_addr,
   output logic               dp_write,
   output logic               dp_a_read,
   output logic               dp_b_read,
   output logic [ALU_W-1:0]   dp_alu_sel,
   output logic               halted,
   output logic               illegal,
   output logic [ADDR_W-1:0]  pc
);

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   pc_q, pc_d;
   logic [INSTR_W-1:0]  ir_q, ir_d;
   logic                z_q, z_d;
   logic                halted_q, halted_d;
   logic                illegal_q, illegal_d;
   ctrl_t               ctrl_q, ctrl_d;

   op_class_t           op_class;
   logic [REG_W-1:0]    rd, ra, rb;
   logic [ADDR_W-1:0]   imm8;
   logic [ALU_W-1:0]    alu_sel;

   // Decode the word about to sit in IR so EXEC strobes can be registered
   // on the same edge that captures the instruction.
   assign ir_d = (state_q == ST_DECODE) ? mb_data_out : ir_q;

   cu_decoder u_decoder (
      .ir       (ir_d),
      .op_class (op_class),
      .rd       (rd),
      .ra       (ra),
      .rb       (rb),
      .imm8     (imm8),
      .alu_sel  (alu_sel)
   );

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      z_d       = z_q;
      halted_d  = halted_q;
      illegal_d = illegal_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d   = ST_FETCH;
               halted_d  = 1'b0;
               illegal_d = 1'b0;
            end
         end
         ST_FETCH:  state_d = ST_DECODE;
         ST_DECODE: begin
            pc_d    = pc_q + 8'd1;
            state_d = ST_EXEC;
         end
         ST_EXEC: begin
            case (op_class)
               CLS_ALU, CLS_LD, CLS_LDI: state_d = ST_WB;
               CLS_ST:  state_d = ST_MEM;
               CLS_JMP: begin
                  pc_d    = imm8;
                  state_d = ST_FETCH;
               end
               CLS_JZ: begin
                  if (z_q) pc_d = imm8;
                  state_d = ST_FETCH;
               end
               CLS_HALT: begin
                  state_d  = ST_IDLE;
                  halted_d = 1'b1;
               end
`ifdef CU_ILLEGAL_TRAP_EN
               CLS_RSVD: begin
                  state_d   = ST_IDLE;
                  halted_d  = 1'b1;
                  illegal_d = 1'b1;
               end
`else
               CLS_RSVD: state_d = ST_FETCH;
`endif
               default: state_d = ST_FETCH;
            endcase
         end
         ST_MEM: state_d = ST_FETCH;
         ST_WB: begin
            if (op_class == CLS_ALU) z_d = dp_zf_flag;
            state_d = ST_FETCH;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Strobes are a function of the state being entered, so they are flops.
   always_comb begin
      ctrl_d = '0;
      case (state_d)
         ST_FETCH: begin
            ctrl_d.mb_pc_addr  = pc_d;
            ctrl_d.mb_mem_read = 1'b1;
         end
         ST_EXEC: begin
            case (op_class)
               CLS_ALU: begin
                  ctrl_d.dp_a_read  = 1'b1;
                  ctrl_d.dp_b_read  = 1'b1;
                  ctrl_d.dp_a_addr  = ra;
                  ctrl_d.dp_b_addr  = rb;
                  ctrl_d.dp_alu_sel = alu_sel;
               end
               CLS_LD: begin
                  ctrl_d.mb_sel      = 1'b1;
                  ctrl_d.mb_cu_addr  = imm8;
                  ctrl_d.mb_mem_read = 1'b1;
               end
               CLS_ST: begin
                  ctrl_d.dp_a_read = 1'b1;
                  ctrl_d.dp_a_addr = rd;
               end
               default: ;
            endcase
         end
         ST_MEM: begin
            ctrl_d.mb_sel       = 1'b1;
            ctrl_d.mb_cu_addr   = imm8;
            ctrl_d.mb_mem_write = 1'b1;
            ctrl_d.dp_a_read    = 1'b1;
            ctrl_d.dp_a_addr    = rd;
         end
         ST_WB: begin
            ctrl_d.dp_write      = 1'b1;
            ctrl_d.dp_write_addr = rd;
            case (op_class)
               CLS_ALU: begin
                  ctrl_d.dp_sel     = DP_SEL_ALU;
                  ctrl_d.dp_a_read  = 1'b1;
                  ctrl_d.dp_b_read  = 1'b1;
                  ctrl_d.dp_a_addr  = ra;
                  ctrl_d.dp_b_addr  = rb;
                  ctrl_d.dp_alu_sel = alu_sel;
               end
               CLS_LD:  ctrl_d.dp_sel = DP_SEL_MEM;
               CLS_LDI: begin
                  ctrl_d.dp_sel = DP_SEL_IMM;
                  ctrl_d.dp_imm = imm8;
               end
               default: ;
            endcase
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK100MHZ) begin
      if (RESET) begin
         state_q   <= ST_IDLE;
         pc_q      <= '0;
         ir_q      <= '0;
         z_q       <= 1'b0;
         halted_q  <= 1'b0;
         illegal_q <= 1'b0;
         ctrl_q    <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         ir_q      <= ir_d;
         z_q       <= z_d;
         halted_q  <= halted_d;
         illegal_q <= illegal_d;
         ctrl_q    <= ctrl_d;
      end
   end

   assign mb_sel        = ctrl_q.mb_sel;
   assign mb_pc_addr    = ctrl_q.mb_pc_addr;
   assign mb_cu_addr    = ctrl_q.mb_cu_addr;
   assign mb_mem_read   = ctrl_q.mb_mem_read;
   assign mb_mem_write  = ctrl_q.mb_mem_write;
   assign dp_imm        = ctrl_q.dp_imm;
   assign dp_sel        = ctrl_q.dp_sel;
   assign dp_write_addr = ctrl_q.dp_write_addr;
   assign dp_a_addr     = ctrl_q.dp_a_addr;
   assign dp_b_addr     = ctrl_q.dp_b_addr;
   assign dp_write      = ctrl_q.dp_write;
   assign dp_a_read     = ctrl_q.dp_a_read;
   assign dp_b_read     = ctrl_q.dp_b_read;
   assign dp_alu_sel    = ctrl_q.dp_alu_sel;
   assign halted        = halted_q;
   assign illegal       = illegal_q;
   assign pc            = pc_q;

endmodule

// File: tb/tb_cpu_control_unit.sv
// Directed bench for cpu_control_unit: a small program runs from a behavioural
// memory; expected strobe values are queued and popped as each cycle is sampled.
module tb_cpu_control_unit;

   logic        CLK100MHZ = 1'b0;
   logic        RESET;
   logic        start;
   logic [15:0] mb_data_out = '0;
   logic        dp_zf_flag;
   logic        mb_sel;
   logic [7:0]  mb_pc_addr, mb_cu_addr;
   logic        mb_mem_read, mb_mem_write;
   logic [7:0]  dp_imm;
   logic [1:0]  dp_sel;
   logic [3:0]  dp_write_addr, dp_a_addr, dp_b_addr;
   logic        dp_write, dp_a_read, dp_b_read;
   logic [3:0]  dp_alu_sel;
   logic        halted, illegal;
   logic [7:0]  pc;

   logic [15:0] mem [256];

   typedef struct {
      string       tag;
      logic [15:0] val;
   } exp_t;
   exp_t sb[$];

   int checks = 0;
   int errors = 0;

   cpu_control_unit dut (
      .CLK100MHZ     (CLK100MHZ),
      .RESET         (RESET),
      .start         (start),
      .mb_data_out   (mb_data_out),
      .dp_zf_flag    (dp_zf_flag),
      .mb_sel        (mb_sel),
      .mb_pc_addr    (mb_pc_addr),
      .mb_cu_addr    (mb_cu_addr),
      .mb_mem_read   (mb_mem_read),
      .mb_mem_write  (mb_mem_write),
      .dp_imm        (dp_imm),
      .dp_sel        (dp_sel),
      .dp_write_addr (dp_write_addr),
      .dp_a_addr     (dp_a_addr),
      .dp_b_addr     (dp_b_addr),
      .dp_write      (dp_write),
      .dp_a_read     (dp_a_read),
      .dp_b_read     (dp_b_read),
      .dp_alu_sel    (dp_alu_sel),
      .halted        (halted),
      .illegal       (illegal),
      .pc            (pc)
   );

   always #5 CLK100MHZ = ~CLK100MHZ;

   // Read data is valid the cycle after the read strobe.
   always @(posedge CLK100MHZ)
      if (mb_mem_read)
         mb_data_out <= mem[mb_sel ? mb_cu_addr : mb_pc_addr];

   task automatic step(input int n);
      repeat (n) begin
         @(posedge CLK100MHZ);
         #1;
      end
   endtask

   task automatic expect_val(input string t, input logic [15:0] v);
      sb.push_back('{t, v});
   endtask

   task automatic check(input logic [15:0] obs);
      exp_t e;
      if (sb.size() == 0) begin
         errors++;
         $error("FAIL scoreboard_empty observed %h", obs);
      end else begin
         e = sb.pop_front();
         checks++;
         assert (obs === e.val)
         else begin
            errors++;
            $error("FAIL %s observed %h expected %h", e.tag, obs, e.val);
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
      mem[8'h00] = 16'h3105;  // LDI R1,05
      mem[8'h01] = 16'h1240;  // LD  R2,[40]
      mem[8'h02] = 16'h8312;  // ALU R3 <- R1 op0 R2 (zero)
      mem[8'h03] = 16'h5020;  // JZ  20 (taken)
      mem[8'h20] = 16'hA312;  // ALU op2 (nonzero)
      mem[8'h21] = 16'h5030;  // JZ  30 (not taken)
      mem[8'h22] = 16'h2180;  // ST  M[80] <- R1
      mem[8'h23] = 16'h6000;  // HALT
      mem[8'h24] = 16'h40FF;  // JMP FF
      mem[8'h40] = 16'h1234;
      mem[8'hFF] = 16'h0000;  // NOP, PC wraps
      RESET = 1'b1;
      start = 1'b0;
      dp_zf_flag = 1'b0;
      step(2);

      expect_val("rst_pc", 16'h00); expect_val("rst_halted", 0);
      expect_val("rst_read", 0);    expect_val("rst_dp_write", 0);
      check(pc); check(halted); check(mb_mem_read); check(dp_write);
      RESET = 1'b0;
      step(1);

      // LDI R1,05
      start = 1'b1; step(1); start = 1'b0;
      expect_val("ldi_f_read", 1); expect_val("ldi_f_addr", 16'h00); expect_val("ldi_f_sel", 0);
      check(mb_mem_read); check(mb_pc_addr); check(mb_sel);
      step(2);
      expect_val("ldi_e_pc", 16'h01); check(pc);
      step(1);
      expect_val("ldi_w_we", 1); expect_val("ldi_w_wa", 1);
      expect_val("ldi_w_sel", 2'b10); expect_val("ldi_w_imm", 16'h05);
      check(dp_write); check(dp_write_addr); check(dp_sel); check(dp_imm);
      $display("txn LDI 3105 pc=%h", pc);

      // LD R2,[40]
      step(1);
      expect_val("ld_f_addr", 16'h01); expect_val("ld_f_dp_write", 0);
      check(mb_pc_addr); check(dp_write);
      step(2);
      expect_val("ld_e_sel", 1); expect_val("ld_e_cu", 16'h40); expect_val("ld_e_read", 1);
      check(mb_sel); check(mb_cu_addr); check(mb_mem_read);
      step(1);
      expect_val("ld_w_sel", 2'b01); expect_val("ld_w_wa", 2); expect_val("ld_w_we", 1);
      check(dp_sel); check(dp_write_addr); check(dp_write);
      $display("txn LD 1240 pc=%h", pc);

      // ALU 8312 with zero result, then JZ 5020 taken
      step(1);
      dp_zf_flag = 1'b1;
      step(2);
      expect_val("alu_e_aread", 1); expect_val("alu_e_aaddr", 1);
      expect_val("alu_e_baddr", 2); expect_val("alu_e_sel", 0);
      check(dp_a_read); check(dp_a_addr); check(dp_b_addr); check(dp_alu_sel);
      step(1);
      expect_val("alu_w_we", 1); expect_val("alu_w_wa", 3);
      expect_val("alu_w_sel", 2'b00); expect_val("alu_w_bread", 1);
      check(dp_write); check(dp_write_addr); check(dp_sel); check(dp_b_read);
      $display("txn ALU 8312 zf=1");
      step(1);
      dp_zf_flag = 1'b0;
      step(3);
      expect_val("jz_taken_pc", 16'h20); expect_val("jz_taken_addr", 16'h20);
      check(pc); check(mb_pc_addr);
      $display("txn JZ 5020 pc=%h", pc);

      // ALU A312 nonzero, JZ 5030 falls through
      step(2);
      expect_val("alu2_e_sel", 2); check(dp_alu_sel);
      step(2);
      step(3);
      expect_val("jz_fall_pc", 16'h22); check(pc);
      $display("txn JZ 5030 pc=%h", pc);

      // ST M[80] <- R1
      step(2);
      expect_val("st_e_aread", 1); expect_val("st_e_aaddr", 1); expect_val("st_e_write", 0);
      check(dp_a_read); check(dp_a_addr); check(mb_mem_write);
      step(1);
      expect_val("st_m_write", 1); expect_val("st_m_cu", 16'h80); expect_val("st_m_sel", 1);
      expect_val("st_m_aaddr", 1); expect_val("st_m_dp_write", 0); expect_val("st_m_read", 0);
      check(mb_mem_write); check(mb_cu_addr); check(mb_sel);
      check(dp_a_addr); check(dp_write); check(mb_mem_read);
      step(1);
      expect_val("st_next_addr", 16'h23); expect_val("st_next_write", 0);
      check(mb_pc_addr); check(mb_mem_write);
      $display("txn ST 2180");

      // HALT, idle, resume
      step(3);
      expect_val("halt_flag", 1); expect_val("halt_read", 0); expect_val("halt_pc", 16'h24);
      check(halted); check(mb_mem_read); check(pc);
      step(2);
      expect_val("halt_idle_read", 0); check(mb_mem_read);
      start = 1'b1; step(1); start = 1'b0;
      expect_val("resume_halted", 0); expect_val("resume_addr", 16'h24); expect_val("resume_read", 1);
      check(halted); check(mb_pc_addr); check(mb_mem_read);
      $display("txn HALT 6000 resumed at %h", mb_pc_addr);

      // JMP FF then NOP at FF wraps PC to 00
      step(3);
      expect_val("jmp_pc", 16'hFF); check(pc);
      step(3);
      expect_val("wrap_pc", 16'h00); expect_val("wrap_addr", 16'h00);
      check(pc); check(mb_pc_addr);
      $display("txn NOP at FF pc=%h", pc);

      // RESET during WB of LDI
      step(3);
      expect_val("wb_pre_reset_we", 1); check(dp_write);
      RESET = 1'b1; step(1);
      expect_val("rst_wb_we", 0); expect_val("rst_wb_pc", 16'h00); expect_val("rst_wb_read", 0);
      check(dp_write); check(pc); check(mb_mem_read);
      RESET = 1'b0;
      $display("txn RESET during WB");

      // Opcode 7
      mem[8'h00] = 16'h7000;
      mem[8'h01] = 16'h3107;
      step(1);
      start = 1'b1; step(1); start = 1'b0;
      step(3);
`ifdef CU_ILLEGAL_TRAP_EN
      expect_val("op7_illegal", 1); expect_val("op7_halted", 1); expect_val("op7_read", 0);
      check(illegal); check(halted); check(mb_mem_read);
      start = 1'b1; step(1); start = 1'b0;
      expect_val("op7_restart_illegal", 0); check(illegal);
`else
      expect_val("op7_illegal", 0); expect_val("op7_halted", 0);
      expect_val("op7_read", 1); expect_val("op7_addr", 16'h01);
      check(illegal); check(halted); check(mb_mem_read); check(mb_pc_addr);
`endif
      $display("txn opcode7 illegal=%0b", illegal);

      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_leftover observed %0d expected 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
